// File: rtl/pic_pkg.sv
// Shared types and opcode prefixes for the literal-ALU CPU sequencer.
package pic_pkg;

  // Instruction-cycle states; t0 is idle, t1..t4 fetch/execute, t5/t6 spare.
  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5,
    T6 = 3'd6
  } state_e;

  // ALU operation select, encoded in this order from 0.
  typedef enum logic [2:0] {
    MOVLW = 3'd0,
    ADDLW = 3'd1,
    SUBLW = 3'd2,
    ANDLW = 3'd3,
    IORLW = 3'd4,
    XORLW = 3'd5
  } alu_op_e;

  // Opcode prefixes, matched against the top bits of the instruction.
  localparam logic [3:0] OPC_MOVLW = 4'b1100;
  localparam logic [4:0] OPC_ADDLW = 5'b11111;
  localparam logic [4:0] OPC_SUBLW = 5'b11110;
  localparam logic [5:0] OPC_ANDLW = 6'b111001;
  localparam logic [5:0] OPC_IORLW = 6'b111000;
  localparam logic [5:0] OPC_XORLW = 6'b111010;
  localparam logic [2:0] OPC_GOTO  = 3'b101;

endpackage

// File: rtl/pic_decode.sv
// Combinational instruction decoder: classifies ir_q and picks the ALU op.
module pic_decode
  import pic_pkg::*;
#(
  parameter int IR_W = 14
) (
  input  logic [IR_W-1:0] ir_q,
  output logic [2:0]      alu_op,
  output logic            is_alu,
  output logic            is_goto,
  output logic            is_nop,
  output logic            is_illegal
);

  // Prefix match; anything that matches no prefix and is not all-zero is illegal.
  always_comb begin
    alu_op  = MOVLW;
    is_alu  = 1'b0;
    is_goto = 1'b0;
    is_nop  = 1'b0;
    if (ir_q == '0) begin
      is_nop = 1'b1;
    end else if (ir_q[IR_W-1 -: 4] == OPC_MOVLW) begin
      is_alu = 1'b1;
      alu_op = MOVLW;
    end else if (ir_q[IR_W-1 -: 5] == OPC_ADDLW) begin
      is_alu = 1'b1;
      alu_op = ADDLW;
    end else if (ir_q[IR_W-1 -: 5] == OPC_SUBLW) begin
      is_alu = 1'b1;
      alu_op = SUBLW;
    end else if (ir_q[IR_W-1 -: 6] == OPC_ANDLW) begin
      is_alu = 1'b1;
      alu_op = ANDLW;
    end else if (ir_q[IR_W-1 -: 6] == OPC_IORLW) begin
      is_alu = 1'b1;
      alu_op = IORLW;
    end else if (ir_q[IR_W-1 -: 6] == OPC_XORLW) begin
      is_alu = 1'b1;
      alu_op = XORLW;
    end else if (ir_q[IR_W-1 -: 3] == OPC_GOTO) begin
      is_goto = 1'b1;
    end
  end

  assign is_illegal = ~(is_alu | is_goto | is_nop);

endmodule

// File: rtl/pic_seq_ctrl.sv
// Instruction-cycle sequencer: t0..t6 FSM, datapath load strobes,
// run/step/halt control and a sticky illegal-opcode flag.
module pic_seq_ctrl
  import pic_pkg::*;
#(
  parameter int IR_W = 14,
  parameter int PC_W = 11,
  parameter int FAST = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            step,
  input  logic [IR_W-1:0] ir_q,
  output logic            load_mar,
  output logic            load_pc,
  output logic            load_pc_goto,
  output logic [PC_W-1:0] goto_addr,
  output logic            load_ir,
  output logic            load_w,
  output logic [2:0]      alu_op,
  output logic            busy,
  output logic            instr_done,
  output logic            illegal
);

  state_e state;
  state_e state_next;
  logic   illegal_next;
  logic   last_state;
  logic   dec_alu;
  logic   dec_goto;
  logic   dec_nop;
  logic   dec_illegal;

  pic_decode #(.IR_W(IR_W)) u_decode (
    .ir_q       (ir_q),
    .alu_op     (alu_op),
    .is_alu     (dec_alu),
    .is_goto    (dec_goto),
    .is_nop     (dec_nop),
    .is_illegal (dec_illegal)
  );

  // The last state is t4 in the short 4-cycle form, t6 otherwise.
  assign last_state = (FAST != 0) ? (state == T4) : (state == T6);
  assign goto_addr  = ir_q[PC_W-1:0];

  // State register and sticky illegal flag, cleared by active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= T0;
      illegal <= 1'b0;
    end else begin
      state   <= state_next;
      illegal <= illegal_next;
    end
  end

  // Next state plus Moore strobe decode; run/step only matter in t0 and the last state.
  always_comb begin
    state_next   = state;
    illegal_next = illegal;
    load_mar     = 1'b0;
    load_pc      = 1'b0;
    load_pc_goto = 1'b0;
    load_ir      = 1'b0;
    load_w       = 1'b0;
    busy         = (state != T0);
    instr_done   = last_state;
    case (state)
      T0: if (!illegal && (run || step)) state_next = T1;
      T1: begin
        load_mar   = 1'b1;
        state_next = T2;
      end
      T2: begin
        load_pc    = 1'b1;
        state_next = T3;
      end
      T3: begin
        load_ir    = 1'b1;
        state_next = T4;
      end
      T4: begin
        load_w       = dec_alu;
        load_pc_goto = dec_goto;
        if (dec_illegal) illegal_next = 1'b1;
        if (FAST != 0) state_next = (run && !illegal_next) ? T1 : T0;
        else           state_next = T5;
      end
      T5: state_next = T6;
      T6: state_next = (run && !illegal_next) ? T1 : T0;
      default: state_next = T0;
    endcase
  end

endmodule

// File: tb/tb_pic_seq_ctrl.sv
// Scoreboard bench for pic_seq_ctrl: a 6-cycle and a 4-cycle instance share
// stimulus; a reference model pushes expected outputs before every clock and
// the observed outputs are popped and compared after it.
module tb_pic_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic [13:0] ir_q = 14'h0000;

  logic        mar0, pc0, gt0, ir0, w0, busy0, done0, ill0;
  logic [10:0] ga0;
  logic [2:0]  op0;
  logic        mar1, pc1, gt1, ir1, w1, busy1, done1, ill1;
  logic [10:0] ga1;
  logic [2:0]  op1;

  pic_seq_ctrl #(.IR_W(14), .PC_W(11), .FAST(0)) dut0 (
    .clk(clk), .rst(rst), .run(run), .step(step), .ir_q(ir_q),
    .load_mar(mar0), .load_pc(pc0), .load_pc_goto(gt0), .goto_addr(ga0),
    .load_ir(ir0), .load_w(w0), .alu_op(op0), .busy(busy0),
    .instr_done(done0), .illegal(ill0)
  );

  pic_seq_ctrl #(.IR_W(14), .PC_W(11), .FAST(1)) dut1 (
    .clk(clk), .rst(rst), .run(run), .step(step), .ir_q(ir_q),
    .load_mar(mar1), .load_pc(pc1), .load_pc_goto(gt1), .goto_addr(ga1),
    .load_ir(ir1), .load_w(w1), .alu_op(op1), .busy(busy1),
    .instr_done(done1), .illegal(ill1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  ctl;    // {mar, pc, goto, ir, w, busy, done, illegal}
    logic        alu_v;  // alu_op is meaningful only for ALU instructions
    logic [2:0]  alu;
    logic [10:0] ga;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  int n_checks = 0;
  int n_errors = 0;
  int m_st[2];
  bit m_ill[2];
  int done_cnt[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Independent opcode classifier: kind 0=nop 1=alu 2=goto 3=illegal.
  function automatic void ref_dec(input logic [13:0] ir, output int kind, output logic [2:0] op);
    kind = 3;
    op   = 3'd0;
    if (ir == 14'h0000) kind = 0;
    else begin
      casez (ir[13:8])
        6'b1100??: begin kind = 1; op = 3'd0; end
        6'b11111?: begin kind = 1; op = 3'd1; end
        6'b11110?: begin kind = 1; op = 3'd2; end
        6'b111001: begin kind = 1; op = 3'd3; end
        6'b111000: begin kind = 1; op = 3'd4; end
        6'b111010: begin kind = 1; op = 3'd5; end
        6'b101???: kind = 2;
        default:   kind = 3;
      endcase
    end
  endfunction

  // Advance reference model d (d=1 is the 4-cycle variant) over one clock and return expected outputs.
  task automatic model(input int d, output exp_t e);
    int kind;
    logic [2:0] op;
    int s;
    ref_dec(ir_q, kind, op);
    s = m_st[d];
    if (!rst) begin
      s = 0;
      m_ill[d] = 1'b0;
    end else begin
      case (s)
        0: if (!m_ill[d] && (run || step)) s = 1;
        1, 2, 3: s = s + 1;
        4: begin
          if (kind == 3) m_ill[d] = 1'b1;
          if (d == 1) s = (run && !m_ill[d]) ? 1 : 0;
          else        s = 5;
        end
        5: s = 6;
        default: s = (run && !m_ill[d]) ? 1 : 0;
      endcase
    end
    m_st[d] = s;
    ref_dec(ir_q, kind, op);
    e.ctl = {s == 1, s == 2, (s == 4) && (kind == 2), s == 3, (s == 4) && (kind == 1),
             s != 0, (d == 1) ? (s == 4) : (s == 6), m_ill[d]};
    e.alu_v = (kind == 1);
    e.alu   = op;
    e.ga    = ir_q[10:0];
  endtask

  // One clock: push predictions, let the edge happen, pop and compare on the falling edge.
  task automatic tick();
    exp_t e;
    model(0, e); exp_q0.push_back(e);
    model(1, e); exp_q1.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = exp_q0.pop_front();
    check("d0.ctl", {24'd0, mar0, pc0, gt0, ir0, w0, busy0, done0, ill0}, {24'd0, e.ctl});
    check("d0.goto_addr", {21'd0, ga0}, {21'd0, e.ga});
    if (e.alu_v) check("d0.alu_op", {29'd0, op0}, {29'd0, e.alu});
    if (done0) done_cnt[0]++;
    e = exp_q1.pop_front();
    check("d1.ctl", {24'd0, mar1, pc1, gt1, ir1, w1, busy1, done1, ill1}, {24'd0, e.ctl});
    check("d1.goto_addr", {21'd0, ga1}, {21'd0, e.ga});
    if (e.alu_v) check("d1.alu_op", {29'd0, op1}, {29'd0, e.alu});
    if (done1) done_cnt[1]++;
    $display("cyc t=%0t run=%0b step=%0b ir=%h st0=%0d st1=%0d ill=%0b/%0b",
             $time, run, step, ir_q, m_st[0], m_st[1], ill0, ill1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    m_st[0] = 0; m_st[1] = 0; m_ill[0] = 1'b0; m_ill[1] = 1'b0;
    done_cnt[0] = 0; done_cnt[1] = 0;

    // Reset, start running NOPs, then reset again while dut0 is in t3.
    rst = 1'b0; ticks(2);
    rst = 1'b1; run = 1'b1; ir_q = 14'h0000;
    for (int i = 0; i < 10 && m_st[0] != 3; i++) tick();
    check("reach_t3", m_st[0], 3);
    rst = 1'b0; ticks(2);
    check("rst_busy", {31'd0, busy0 | busy1}, 32'd0);
    rst = 1'b1;

    // Continuous run over several instruction kinds.
    ir_q = 14'h3E05; ticks(13);   // ADDLW 5
    ir_q = 14'h3005; ticks(12);   // MOVLW 5
    ir_q = 14'h2810; ticks(12);   // GOTO 0x010
    ir_q = 14'h3FFF; ticks(12);   // still ADDLW
    ir_q = 14'h3905; ticks(12);   // ANDLW
    ir_q = 14'h3A05; ticks(12);   // XORLW
    ir_q = 14'h3C05; ticks(12);   // SUBLW

    // Single step: one pulse in t0, a second one while busy must be ignored.
    run = 1'b0;
    for (int i = 0; i < 12 && (m_st[0] != 0 || m_st[1] != 0); i++) tick();
    check("idle_before_step", {31'd0, busy0 | busy1}, 32'd0);
    ir_q = 14'h3805;              // IORLW
    done_cnt[0] = 0; done_cnt[1] = 0;
    step = 1'b1; tick();
    step = 1'b0; ticks(2);
    step = 1'b1; tick();
    step = 1'b0; ticks(8);
    check("step_done_cnt0", done_cnt[0], 1);
    check("step_done_cnt1", done_cnt[1], 1);
    check("step_idle", {31'd0, busy0 | busy1}, 32'd0);

    // Run drop mid-instruction: the instruction completes, then idle.
    run = 1'b1; ir_q = 14'h3E01;
    ticks(5);
    for (int i = 0; i < 8 && m_st[1] != 2; i++) tick();
    check("fast_reach_t2", m_st[1], 2);
    run = 1'b0; ticks(8);
    check("drop_idle", {31'd0, busy0 | busy1}, 32'd0);

    // Illegal opcode: sticky flag, halt with run held, step ignored until reset.
    run = 1'b1; ir_q = 14'h0100; ticks(14);
    check("illegal_set", {30'd0, ill0, ill1}, 32'd3);
    ir_q = 14'h3E05;
    step = 1'b1; tick();
    step = 1'b0; ticks(3);
    run = 1'b0; step = 1'b1; tick();
    step = 1'b0; ticks(3);
    check("illegal_halt", {31'd0, busy0 | busy1}, 32'd0);
    rst = 1'b0; tick();
    rst = 1'b1; run = 1'b1; ticks(8);
    check("restart_after_rst", {31'd0, ill0 | ill1}, 32'd0);
    run = 1'b0; ticks(8);

    check("queue_drained", exp_q0.size() + exp_q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
